// File: rtl/hw_button_pio_pkg.sv
// Shared definitions for the PIO blocks: register word offsets, edge-select codes
// and the edge-select helper used by the input PIO.
package hw_button_pio_pkg;

   localparam logic [1:0] PIO_DATA    = 2'd0;
   localparam logic [1:0] PIO_DIR     = 2'd1;
   localparam logic [1:0] PIO_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // Vectors are carried at full bus width so the helper is independent of WIDTH.
   function automatic logic [31:0] pio_edge_sel(input logic [31:0] rise,
                                                input logic [31:0] fall,
                                                input int          edge_type);
      logic [31:0] sel;
      case (edge_type)
         EDGE_RISE: sel = rise;
         EDGE_FALL: sel = fall;
         default:   sel = rise | fall;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/hw_pio_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
// The output changes only after the synchronised input has differed for DEBOUNCE_CYCLES cycles.
module hw_pio_debounce
   import hw_button_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic stable
);

   logic meta_q;
   logic sync_q;
   logic stable_q;
   logic stable_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_comb begin
            stable_d = sync_q;
         end
      end else begin : g_count
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
         localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Any cycle where sync matches stable restarts the count from zero.
         always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync_q != stable_q) begin
               if (cnt_q == CNT_LAST) begin
                  stable_d = sync_q;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= 1'b0;
      end else begin
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/hw_button_pio.sv
// Avalon-MM input PIO: debounced button/switch inputs, sticky edge capture with
// write-1-to-clear, interrupt mask and a registered level IRQ.
module hw_button_pio
   import hw_button_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] edge_capture_q;
   logic [WIDTH-1:0] edge_capture_d;
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] irq_mask_d;
   logic [31:0]      readdata_q;
   logic [31:0]      readdata_d;
   logic             irq_q;
   logic             irq_d;
   logic             bus_wr;
   logic [31:0]      edge_sel_w;
   logic             unused_wdata;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         hw_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .stable  (stable[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d_q <= '0;
      end else begin
         stable_d_q <= stable;
      end
   end

   assign bus_wr       = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      logic [31:0] rise_w;
      logic [31:0] fall_w;
      rise       = stable & ~stable_d_q;
      fall       = ~stable & stable_d_q;
      rise_w     = '0;
      fall_w     = '0;
      rise_w[WIDTH-1:0] = rise;
      fall_w[WIDTH-1:0] = fall;
      edge_sel_w = pio_edge_sel(rise_w, fall_w, EDGE_TYPE);
      edge_hit   = edge_sel_w[WIDTH-1:0];
   end

   // New edges are OR-ed in after the clear so a same-cycle edge is never lost.
   always_comb begin
      cap_clr        = '0;
      irq_mask_d     = irq_mask_q;
      if (bus_wr && (address == PIO_EDGECAP)) begin
         cap_clr = writedata[WIDTH-1:0];
      end
      if (bus_wr && (address == PIO_IRQMASK)) begin
         irq_mask_d = writedata[WIDTH-1:0];
      end
      edge_capture_d = (edge_capture_q & ~cap_clr) | edge_hit;
      irq_d          = |(edge_capture_q & irq_mask_q);
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         PIO_DATA:    readdata_d[WIDTH-1:0] = stable;
         PIO_DIR:     readdata_d = '0;
         PIO_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
         PIO_EDGECAP: readdata_d[WIDTH-1:0] = edge_capture_q;
         default:     readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture_q <= '0;
         irq_mask_q     <= '0;
         readdata_q     <= '0;
         irq_q          <= 1'b0;
      end else begin
         edge_capture_q <= edge_capture_d;
         irq_mask_q     <= irq_mask_d;
         readdata_q     <= readdata_d;
         irq_q          <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_hw_button_pio.sv
// Directed bench for hw_button_pio: a register-access vector table plus timed
// sequences for debounce latency, bounce rejection, IRQ, mask and clear collision.
module tb_hw_button_pio;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_a;
   logic [3:0]  in_b;
   logic [31:0] rd_a;
   logic [31:0] rd_b;
   logic        irq_a;
   logic        irq_b;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   typedef struct {
      logic        is_wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
      string       name;
   } vec_t;

   vec_t vecs [16];

   hw_button_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .CNT_W(16)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a),
      .readdata(rd_a), .irq(irq_a)
   );

   hw_button_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .CNT_W(16)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_b),
      .readdata(rd_b), .irq(irq_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_rd(input logic [1:0] a);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      tick();
      chipselect = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0000000F, 1'b0, "data_all_high"};
      vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0,        1'b0, "dir_reads_zero"};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0, "mask_reset"};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0,        1'b0, "edgecap_reset"};
      vecs[4]  = '{1'b1, 2'd1, 32'h0000FFFF, 32'h0,        1'b0, "dir_write"};
      vecs[5]  = '{1'b0, 2'd1, 32'h0,        32'h0,        1'b0, "dir_ro"};
      vecs[6]  = '{1'b1, 2'd2, 32'h0000000A, 32'h0,        1'b0, "mask_write_a"};
      vecs[7]  = '{1'b0, 2'd2, 32'h0,        32'h0000000A, 1'b0, "mask_read_a"};
      vecs[8]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h0,        1'b0, "mask_write_ones"};
      vecs[9]  = '{1'b0, 2'd2, 32'h0,        32'h0000000F, 1'b0, "mask_width"};
      vecs[10] = '{1'b1, 2'd2, 32'h0,        32'h0,        1'b0, "mask_write_zero"};
      vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h0,        1'b0, "mask_read_zero"};
      vecs[12] = '{1'b1, 2'd0, 32'h00000005, 32'h0,        1'b0, "data_write"};
      vecs[13] = '{1'b0, 2'd0, 32'h0,        32'h0000000F, 1'b0, "data_ro"};
      vecs[14] = '{1'b1, 2'd3, 32'h0000000F, 32'h0,        1'b0, "edgecap_clr_empty"};
      vecs[15] = '{1'b0, 2'd3, 32'h0,        32'h0,        1'b0, "edgecap_still_zero"};

      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_a       = 4'hF;
      in_b       = 4'h0;
      tick(3);
      check("reset_readdata", rd_a, 32'h0);
      check("reset_irq", {31'b0, irq_a}, 32'h0);
      reset_n = 1'b1;
      tick(10);

      // Test 1: register access table
      foreach (vecs[k]) begin
         if (vecs[k].is_wr) begin
            bus_wr(vecs[k].addr, vecs[k].wdata);
         end else begin
            bus_rd(vecs[k].addr);
            check(vecs[k].name, rd_a, vecs[k].exp_rd);
         end
         check({vecs[k].name, "_irq"}, {31'b0, irq_a}, {31'b0, vecs[k].exp_irq});
      end

      // Test 2: bounce rejection and exact debounce latency on bit 0
      chipselect = 1'b1;
      address    = 2'd0;
      in_a = 4'hE;
      tick(2);
      in_a = 4'hF;
      tick(2);
      in_a = 4'hE;
      tick(6);
      check("bounce_hold", rd_a, 32'h0000000F);
      tick();
      check("bounce_fall", rd_a, 32'h0000000E);
      bus_rd(2'd3);
      check("bounce_edgecap", rd_a, 32'h00000001);

      // Test 3: IRQ raise and clear
      bus_wr(2'd3, 32'h1);
      in_a = 4'hF;
      tick(10);
      bus_rd(2'd3);
      check("rise_not_captured", rd_a, 32'h0);
      bus_wr(2'd2, 32'h1);
      in_a = 4'hE;
      tick(7);
      check("irq_pre", {31'b0, irq_a}, 32'h0);
      tick();
      check("irq_rise", {31'b0, irq_a}, 32'h1);
      bus_wr(2'd3, 32'h1);
      check("irq_hold", {31'b0, irq_a}, 32'h1);
      tick();
      check("irq_clear", {31'b0, irq_a}, 32'h0);
      bus_rd(2'd3);
      check("edgecap_cleared", rd_a, 32'h0);

      // Test 4: masked capture on bit 2
      in_a = 4'hA;
      tick(10);
      check("mask_blocks", {31'b0, irq_a}, 32'h0);
      bus_rd(2'd3);
      check("mask_edgecap", rd_a, 32'h00000004);
      bus_wr(2'd2, 32'h4);
      check("mask_wr_cycle", {31'b0, irq_a}, 32'h0);
      tick();
      check("mask_raise", {31'b0, irq_a}, 32'h1);

      // Test 5: clear of bit 1 in the same cycle as a new bit-1 edge
      bus_wr(2'd3, 32'h4);
      bus_wr(2'd2, 32'h2);
      tick();
      check("collide_idle_irq", {31'b0, irq_a}, 32'h0);
      in_a = 4'h8;
      tick(6);
      bus_wr(2'd3, 32'h2);
      bus_rd(2'd3);
      check("collide_cap", rd_a, 32'h00000002);
      check("collide_irq", {31'b0, irq_a}, 32'h1);

      // Test 6: bypassed debounce, any-edge capture on dut_b bit 3
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = 2'd0;
      in_b = 4'h8;
      tick(3);
      check("b_latency_pre", rd_b, 32'h0);
      in_b = 4'h0;
      tick();
      check("b_latency_post", rd_b, 32'h00000008);
      tick(6);
      bus_rd(2'd3);
      check("b_any_edgecap", rd_b, 32'h00000008);
      check("b_irq_masked", {31'b0, irq_b}, 32'h0);
      bus_wr(2'd0, 32'hFF);
      bus_rd(2'd0);
      check("b_data_ro", rd_b, 32'h0);

      // Test 7: reset in the middle of a debounce count
      in_a = 4'h9;
      tick(4);
      reset_n = 1'b0;
      tick(2);
      check("rst_mid_readdata", rd_a, 32'h0);
      check("rst_mid_irq", {31'b0, irq_a}, 32'h0);
      reset_n    = 1'b1;
      chipselect = 1'b1;
      address    = 2'd0;
      tick(6);
      check("rst_redebounce_pre", rd_a, 32'h0);
      tick();
      check("rst_redebounce_post", rd_a, 32'h00000009);
      bus_rd(2'd3);
      check("rst_rise_not_captured", rd_a, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
